additive_harmonic_engine: RTL and testbench

- Parametrised additive-synthesis core and successor to the fixed 5-harmonic loop.
- On each sample tick it advances up to NUM_HARMONICS per-harmonic phase accumulators and reads an external sine LUT, one harmonic per clock.
- Each harmonic is scaled by a geometric amplitude decay and summed; harmonics at or above Nyquist are skipped.
- Emits one saturated, offset-binary sample per tick for the DAC SPI block.

---
 rtl/additive_harmonic_engine.sv | 217 +++++++++++++++++++++
 tb/tb_additive_harmonic_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/additive_harmonic_engine.sv
`default_nettype none
// ============================================================================
//  Module   : additive_harmonic_engine
//  Purpose  : Additive-synthesis core. On every sample tick it steps up to
//             NUM_HARMONICS phase accumulators, reads an external sine LUT
//             one harmonic per clock, and weights each harmonic by a geometric
//             amplitude decay. It sums the weighted harmonics and emits one
//             saturated, offset-binary sample. Harmonics at or above Nyquist
//             are skipped.
//  Revision : 1.0  initial release
// ============================================================================
module additive_harmonic_engine #(
    parameter int NUM_HARMONICS = 64,
    parameter int HARM_W        = 7,
    parameter int PHASE_W       = 32,
    parameter int LUT_ADDR_W    = 11,
    parameter int SAMPLE_W      = 16,
    parameter int ACC_W         = 32,
    parameter int OUT_SHIFT     = 2,
    parameter int LUT_LATENCY   = 2
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic                  sample_tick,
    input  logic [PHASE_W-1:0]    freq_inc,
    input  logic [HARM_W-1:0]     num_harmonics,
    input  logic                  odd_only,
    input  logic [15:0]           decay,
    input  logic                  clear_overrun,
    output logic [LUT_ADDR_W-1:0] lut_addr,
    input  logic [SAMPLE_W-1:0]   lut_data,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int IDX_W   = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
    localparam int CNT_W   = HARM_W + 1;
    localparam int INC_W   = PHASE_W + HARM_W;
    localparam int DRAIN_W = $clog2(LUT_LATENCY + 2);
    localparam int PROD_W  = SAMPLE_W + 17;

    localparam logic [INC_W-1:0]        NYQUIST  = INC_W'(1) << (PHASE_W - 1);
    localparam logic [HARM_W-1:0]       HARM_MAX = HARM_W'(NUM_HARMONICS);
    localparam logic [DRAIN_W-1:0]      DRAIN_LD = DRAIN_W'(LUT_LATENCY + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                   state;
    logic [PHASE_W-1:0]       phase [NUM_HARMONICS];
    logic [PHASE_W-1:0]       lat_freq;
    logic [HARM_W-1:0]        lat_count;
    logic                     lat_odd;
    logic [15:0]              lat_decay;
    logic [CNT_W-1:0]         harm_cnt;      // harmonic number minus one
    logic [INC_W-1:0]         inc_word;      // n * freq_inc, never wraps
    logic [15:0]              level;
    logic [DRAIN_W-1:0]       drain_cnt;

    logic                     tag_valid [0:LUT_LATENCY];
    logic [15:0]              tag_level [0:LUT_LATENCY];
    logic                     prod_valid;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  acc;

    logic                     accept;
    logic                     can_issue;
    logic                     issue;
    logic [IDX_W-1:0]         wr_idx;
    logic [PHASE_W-1:0]       new_phase;
    logic [31:0]              next_level_full;
    logic [15:0]              weight;
    logic [HARM_W-1:0]        clamped_count;
    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] weight_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  shifted;
    logic [SAMPLE_W-1:0]      saturated;

    // A tick is taken in IDLE and also in OUT, where the engine is about to go idle
    assign accept        = sample_tick && (state == S_IDLE || state == S_OUT);
    assign clamped_count = (num_harmonics > HARM_MAX) ? HARM_MAX : num_harmonics;
    // inc_word grows with n, so the first harmonic at Nyquist ends the run
    assign can_issue     = (harm_cnt < {1'b0, lat_count}) && (inc_word < NYQUIST);
    assign issue         = (state == S_RUN) && can_issue;
    assign wr_idx        = IDX_W'(harm_cnt);
    assign new_phase     = phase[wr_idx] + inc_word[PHASE_W-1:0];
    assign next_level_full = {16'd0, level} * {16'd0, lat_decay};
    // harm_cnt odd means harmonic number n is even
    assign weight        = (lat_odd && harm_cnt[0]) ? 16'd0 : level;

    assign data_ext   = {{17{lut_data[SAMPLE_W-1]}}, lut_data};
    assign weight_ext = {{(SAMPLE_W + 1){1'b0}}, tag_level[LUT_LATENCY]};
    assign product    = data_ext * weight_ext;
    assign shifted    = acc >>> OUT_SHIFT;

    // Clamp the scaled accumulator to the signed sample range
    always_comb begin
        saturated = SAMPLE_W'(shifted);
        if (shifted > SAT_MAX) begin
            saturated = SAMPLE_W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            saturated = SAMPLE_W'(SAT_MIN);
        end
    end

    // Control FSM: latches the request, issues one harmonic per clock, drains, outputs
    always_ff @(posedge clock) begin
        if (!rstn) begin
            state        <= S_IDLE;
            lat_freq     <= '0;
            lat_count    <= '0;
            lat_odd      <= 1'b0;
            lat_decay    <= '0;
            harm_cnt     <= '0;
            inc_word     <= '0;
            level        <= '0;
            drain_cnt    <= '0;
            lut_addr     <= '0;
            sample_out   <= {1'b1, {(SAMPLE_W - 1){1'b0}}};
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < NUM_HARMONICS; i++) begin
                phase[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;

            if (sample_tick && busy && !accept) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                end
                S_RUN: begin
                    if (can_issue) begin
                        phase[wr_idx] <= new_phase;
                        lut_addr      <= new_phase[PHASE_W-1 -: LUT_ADDR_W];
                        harm_cnt      <= harm_cnt + 1'b1;
                        inc_word      <= inc_word + {{HARM_W{1'b0}}, lat_freq};
                        level         <= 16'(next_level_full >> 16);
                    end else begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_LD;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= S_OUT;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                S_OUT: begin
                    sample_out   <= {~saturated[SAMPLE_W-1], saturated[SAMPLE_W-2:0]};
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                lat_freq  <= freq_inc;
                lat_count <= clamped_count;
                lat_odd   <= odd_only;
                lat_decay <= decay;
                harm_cnt  <= '0;
                inc_word  <= {{HARM_W{1'b0}}, freq_inc};
                level     <= 16'hFFFF;
                busy      <= 1'b1;
                state     <= S_RUN;
            end
        end
    end

    // Datapath: carry each harmonic's weight alongside its LUT read, then scale and sum
    always_ff @(posedge clock) begin
        if (!rstn) begin
            for (int i = 0; i <= LUT_LATENCY; i++) begin
                tag_valid[i] <= 1'b0;
                tag_level[i] <= '0;
            end
            prod_valid <= 1'b0;
            prod       <= '0;
            acc        <= '0;
        end else begin
            tag_valid[0] <= issue;
            tag_level[0] <= weight;
            for (int i = 1; i <= LUT_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_level[i] <= tag_level[i-1];
            end
            prod_valid <= tag_valid[LUT_LATENCY];
            prod       <= ACC_W'(product >>> 16);
            if (accept) begin
                acc <= '0;
            end else if (prod_valid) begin
                acc <= acc + prod;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_additive_harmonic_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_additive_harmonic_engine
//  Purpose  : Directed self-checking bench for additive_harmonic_engine with a
//             two-clock LUT model (ideal sine points or a constant value).
//  Revision : 1.0  initial release
// ============================================================================
module tb_additive_harmonic_engine;

    logic        clock = 1'b0;
    logic        rstn = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] freq_inc = '0;
    logic [6:0]  num_harmonics = '0;
    logic        odd_only = 1'b0;
    logic [15:0] decay = '0;
    logic        clear_overrun = 1'b0;
    logic [10:0] lut_addr;
    logic [15:0] lut_data = '0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    logic        use_const = 1'b1;
    logic [15:0] const_val = '0;
    logic [15:0] lut_s1 = '0;

    int checks = 0;
    int failures = 0;

    additive_harmonic_engine dut (
        .clock         (clock),
        .rstn          (rstn),
        .sample_tick   (sample_tick),
        .freq_inc      (freq_inc),
        .num_harmonics (num_harmonics),
        .odd_only      (odd_only),
        .decay         (decay),
        .clear_overrun (clear_overrun),
        .lut_addr      (lut_addr),
        .lut_data      (lut_data),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    // Ideal 2048-entry sine (amplitude 32767) at the multiples of 256 used here
    function automatic logic [15:0] sine_at(input logic [10:0] a);
        case (a)
            11'd0:    return 16'h0000;
            11'd256:  return 16'h5A82;   //  23170
            11'd512:  return 16'h7FFF;   //  32767
            11'd768:  return 16'h5A82;
            11'd1024: return 16'h0000;
            11'd1280: return 16'hA57E;   // -23170
            11'd1536: return 16'h8001;   // -32767
            11'd1792: return 16'hA57E;
            default:  return 16'h0000;
        endcase
    endfunction

    // Fundamental-only expected sample: level 0xFFFF, >>>16, >>>2, offset binary
    function automatic logic [15:0] fund_expect(input logic [10:0] a);
        longint d, c, s;
        d = longint'($signed(sine_at(a)));
        c = (d * 65535) >>> 16;
        s = c >>> 2;
        return 16'(s + 32768);
    endfunction

    // LUT model with two clocks of read latency
    always @(posedge clock) begin
        lut_s1   <= use_const ? const_val : sine_at(lut_addr);
        lut_data <= lut_s1;
    end

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clock);
        #1 rstn = 1'b1;
    endtask

    task automatic tick_wait(output int lat);
        sample_tick = 1'b1;
        @(posedge clock);
        #1 sample_tick = 1'b0;
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clock);
            #1;
            if (sample_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (sample_out !== 16'h8000) begin failures++; $display("FAIL reset_sample_out got %h want 8000", sample_out); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", sample_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (lut_addr !== 11'd0) begin failures++; $display("FAIL reset_lut_addr got %0d want 0", lut_addr); end
        rstn = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        checks++; if (sample_out !== 16'h8000 || busy !== 1'b0 || sample_valid !== 1'b0)
            begin failures++; $display("FAIL idle_hold got out=%h busy=%b valid=%b want 8000/0/0", sample_out, busy, sample_valid); end
    endtask

    task automatic test_fundamental();
        int lat;
        logic [10:0] ea;
        do_reset();
        use_const = 1'b0;
        freq_inc = 32'h2000_0000; num_harmonics = 7'd1; odd_only = 1'b0; decay = 16'hFFFF;
        for (int k = 1; k <= 9; k++) begin
            tick_wait(lat);
            ea = 11'((k * 256) % 2048);
            checks++; if (lat !== 7) begin failures++; $display("FAIL fund_latency tick %0d got %0d want 7", k, lat); end
            checks++; if (lut_addr !== ea) begin failures++; $display("FAIL fund_lut_addr tick %0d got %0d want %0d", k, lut_addr, ea); end
            checks++; if (sample_out !== fund_expect(ea)) begin failures++; $display("FAIL fund_sample tick %0d got %h want %h", k, sample_out, fund_expect(ea)); end
        end
    endtask

    task automatic test_nyquist();
        int lat, changes;
        logic [10:0] prev;
        do_reset();
        use_const = 1'b0;
        freq_inc = 32'h2000_0000; num_harmonics = 7'd8; odd_only = 1'b0; decay = 16'hFFFF;
        prev = lut_addr; changes = 0; lat = -1;
        sample_tick = 1'b1;
        @(posedge clock);
        #1 sample_tick = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clock);
            #1;
            if (lut_addr !== prev) changes++;
            prev = lut_addr;
            if (sample_valid) begin lat = i; break; end
        end
        checks++; if (changes !== 3) begin failures++; $display("FAIL nyq_issues got %0d want 3", changes); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL nyq_latency got %0d want 9", lat); end
        checks++; if (lut_addr !== 11'd768) begin failures++; $display("FAIL nyq_last_addr got %0d want 768", lut_addr); end
        // 23169 + 32766 + 23168 = 79103, >>>2 = 19775 -> 0xCD3F
        checks++; if (sample_out !== 16'hCD3F) begin failures++; $display("FAIL nyq_sample got %h want cd3f", sample_out); end
    endtask

    task automatic test_k_zero();
        int lat;
        do_reset();
        use_const = 1'b1; const_val = 16'h4000;
        freq_inc = 32'h8000_0000; num_harmonics = 7'd5; odd_only = 1'b0; decay = 16'hFFFF;
        tick_wait(lat);
        checks++; if (lat !== 6) begin failures++; $display("FAIL k0_nyq_latency got %0d want 6", lat); end
        checks++; if (sample_out !== 16'h8000) begin failures++; $display("FAIL k0_nyq_sample got %h want 8000", sample_out); end
        freq_inc = 32'h0000_0100; num_harmonics = 7'd0;
        tick_wait(lat);
        checks++; if (lat !== 6) begin failures++; $display("FAIL k0_count_latency got %0d want 6", lat); end
        checks++; if (lut_addr !== 11'd0) begin failures++; $display("FAIL k0_no_issue got %0d want 0", lut_addr); end
    endtask

    task automatic test_clamp();
        int lat;
        do_reset();
        use_const = 1'b1; const_val = 16'h0000;
        freq_inc = 32'h0000_0001; num_harmonics = 7'd100; odd_only = 1'b0; decay = 16'hFFFF;
        tick_wait(lat);
        checks++; if (lat !== 70) begin failures++; $display("FAIL clamp_latency got %0d want 70", lat); end
    endtask

    task automatic test_odd_decay();
        int lat;
        do_reset();
        use_const = 1'b1; const_val = 16'd16384;
        freq_inc = 32'h0100_0000; num_harmonics = 7'd4; odd_only = 1'b1; decay = 16'h8000;
        tick_wait(lat);
        checks++; if (lat !== 10) begin failures++; $display("FAIL odd_latency got %0d want 10", lat); end
        checks++; if (sample_out !== 16'h93FF) begin failures++; $display("FAIL odd_sample got %h want 93ff", sample_out); end
        odd_only = 1'b0;
    endtask

    task automatic test_saturation();
        int lat;
        do_reset();
        use_const = 1'b1; const_val = 16'h7FFF;
        freq_inc = 32'h0000_0001; num_harmonics = 7'd64; odd_only = 1'b0; decay = 16'hFFFF;
        tick_wait(lat);
        checks++; if (lat !== 70) begin failures++; $display("FAIL sat_latency got %0d want 70", lat); end
        checks++; if (sample_out !== 16'hFFFF) begin failures++; $display("FAIL sat_pos got %h want ffff", sample_out); end
        const_val = 16'h8000;
        tick_wait(lat);
        checks++; if (sample_out !== 16'h0000) begin failures++; $display("FAIL sat_neg got %h want 0000", sample_out); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_reset();
        use_const = 1'b0;
        freq_inc = 32'h2000_0000; num_harmonics = 7'd1; odd_only = 1'b0; decay = 16'hFFFF;
        sample_tick = 1'b1;
        @(posedge clock);
        #1 sample_tick = 1'b0;
        repeat (6) @(posedge clock);
        #1 sample_tick = 1'b1;
        @(posedge clock);
        #1 sample_tick = 1'b0;
        checks++; if (sample_valid !== 1'b1 || busy !== 1'b1)
            begin failures++; $display("FAIL b2b_first got valid=%b busy=%b want 1/1", sample_valid, busy); end
        checks++; if (sample_out !== 16'h96A0) begin failures++; $display("FAIL b2b_first_sample got %h want 96a0", sample_out); end
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clock);
            #1;
            if (sample_valid) begin lat = i; break; end
        end
        checks++; if (lat !== 7) begin failures++; $display("FAIL b2b_second_latency got %0d want 7", lat); end
        checks++; if (sample_out !== 16'h9FFF) begin failures++; $display("FAIL b2b_second_sample got %h want 9fff", sample_out); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        int valids;
        do_reset();
        use_const = 1'b1; const_val = 16'h1000;
        freq_inc = 32'h2000_0000; num_harmonics = 7'd1; odd_only = 1'b0; decay = 16'hFFFF;
        // second tick three clocks after the first
        sample_tick = 1'b1;
        @(posedge clock);
        #1 sample_tick = 1'b0;
        repeat (2) @(posedge clock);
        #1 sample_tick = 1'b1;
        @(posedge clock);
        #1 sample_tick = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got %b want 1", overrun); end
        valids = 0;
        for (int i = 0; i < 20; i++) begin @(posedge clock); #1; if (sample_valid) valids++; end
        checks++; if (valids !== 1) begin failures++; $display("FAIL ovr_one_valid got %0d want 1", valids); end
        clear_overrun = 1'b1;
        @(posedge clock);
        #1 clear_overrun = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got %b want 0", overrun); end
        // clear and a new overrun event in the same clock: set wins
        sample_tick = 1'b1;
        @(posedge clock);
        #1 sample_tick = 1'b0;
        repeat (2) @(posedge clock);
        #1 begin sample_tick = 1'b1; clear_overrun = 1'b1; end
        @(posedge clock);
        #1 begin sample_tick = 1'b0; clear_overrun = 1'b0; end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
        valids = 0;
        for (int i = 0; i < 20; i++) begin @(posedge clock); #1; if (sample_valid) valids++; end
        checks++; if (valids !== 1) begin failures++; $display("FAIL ovr_set_wins_valid got %0d want 1", valids); end
        // reset in the middle of a long run
        freq_inc = 32'h0000_0001; num_harmonics = 7'd64;
        sample_tick = 1'b1;
        @(posedge clock);
        #1 sample_tick = 1'b0;
        repeat (3) @(posedge clock);
        #1 rstn = 1'b0;
        @(posedge clock);
        #1 rstn = 1'b1;
        checks++; if (sample_out !== 16'h8000 || busy !== 1'b0 || overrun !== 1'b0 || lut_addr !== 11'd0)
            begin failures++; $display("FAIL midrun_reset got out=%h busy=%b ovr=%b addr=%0d want 8000/0/0/0", sample_out, busy, overrun, lut_addr); end
        valids = 0;
        for (int i = 0; i < 100; i++) begin @(posedge clock); #1; if (sample_valid) valids++; end
        checks++; if (valids !== 0) begin failures++; $display("FAIL midrun_no_valid got %0d want 0", valids); end
    endtask

    initial begin
        test_reset();
        test_fundamental();
        test_nyquist();
        test_k_zero();
        test_clamp();
        test_odd_decay();
        test_saturation();
        test_back_to_back();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
